// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//
// Purpose:
//   Shared constants for the decode/issue slice that feeds the execute-stage
//   ALU: the 5-bit ALU operation codes, the RV32 major opcodes handled here,
//   the funct7 patterns that select base / alternate / multiply forms, and a
//   helper that maps funct3 onto the base integer operations.
//
// Ports:
//   none (package)
//
// Configuration:
//   ALU_ISSUE_FWD_EN is consumed by alu_issue_stage only; nothing here
//   depends on it.
// ---------------------------------------------------------------------------
package alu_pkg;

  // Width of the operation code driven to the ALU.
  localparam int ALU_OPW = 5;

  // ALU operation codes as understood by the execute stage.
  localparam logic [4:0] ALU_AND  = 5'd0;
  localparam logic [4:0] ALU_OR   = 5'd1;
  localparam logic [4:0] ALU_ADD  = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd3;
  localparam logic [4:0] ALU_SLL  = 5'd4;
  localparam logic [4:0] ALU_SRL  = 5'd5;
  localparam logic [4:0] ALU_SRA  = 5'd6;
  localparam logic [4:0] ALU_XOR  = 5'd7;
  localparam logic [4:0] ALU_MUL  = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;
  localparam logic [4:0] ALU_SLTU = 5'd10;

  // Major opcodes (instr[6:0]) decoded by this stage.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // funct7 patterns: plain integer op, alternate (SUB/SRA), M-extension.
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 field values that carry a shift amount instead of a full operand.
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // Base integer operation selected by funct3 when funct7 is the plain
  // pattern. OP and OP-IMM share this mapping; SRL here becomes SRA when the
  // alternate funct7 is present, which the caller handles.
  function automatic logic [4:0] base_op(input logic [2:0] funct3);
    logic [4:0] op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
//
// Purpose:
//   Purely combinational decode of one instruction into the operand pair and
//   operation code that the execute-stage ALU consumes. Handles RV32I OP,
//   OP-IMM, LUI, AUIPC and RV32M MUL; everything else is flagged illegal and
//   turned into a harmless ADD of zeros with write-back suppressed.
//
// Ports:
//   i_instr    in  32    raw instruction word
//   i_pc       in  XLEN  pc of the instruction (AUIPC operand A)
//   i_rs1_data in  XLEN  rs1 value (already forwarded if applicable)
//   i_rs2_data in  XLEN  rs2 value (already forwarded if applicable)
//   o_reg1     out XLEN  ALU operand A
//   o_reg2     out XLEN  ALU operand B
//   o_alu_op   out 5     ALU operation code
//   o_rd       out 5     destination register index
//   o_we       out 1     legal and rd != x0
//   o_illegal  out 1     instruction not handled by this stage
//
// Configuration:
//   no macros; ALU_ISSUE_FWD_EN is resolved before the operands reach here.
// ---------------------------------------------------------------------------
module alu_op_decode #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic [XLEN-1:0] o_reg1,
  output logic [XLEN-1:0] o_reg2,
  output logic [4:0]      o_alu_op,
  output logic [4:0]      o_rd,
  output logic            o_we,
  output logic            o_illegal
);

  import alu_pkg::*;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt_imm;
  logic [XLEN-1:0] w_shamt_reg;
  logic            w_legal;
  logic [XLEN-1:0] w_reg1;
  logic [XLEN-1:0] w_reg2;
  logic [4:0]      w_alu_op;

  // Instruction fields and the immediate forms used as operand B.
  assign w_opcode    = i_instr[6:0];
  assign w_rd        = i_instr[11:7];
  assign w_funct3    = i_instr[14:12];
  assign w_funct7    = i_instr[31:25];
  assign w_imm_i     = XLEN'($signed(i_instr[31:20]));
  assign w_imm_u     = XLEN'($signed({i_instr[31:12], 12'b0}));
  assign w_shamt_imm = XLEN'(i_instr[24:20]);

  // The ALU shifts by its whole operand B, so register shift amounts are
  // trimmed to five bits here rather than in the execute stage.
  assign w_shamt_reg = XLEN'(i_rs2_data[4:0]);

  // Main decode. Operand selection is done first; an illegal encoding then
  // overrides everything to ADD 0,0 so the execute stage sees a benign op
  // while the illegal flag carries the exception downstream.
  always_comb begin
    w_legal  = 1'b0;
    w_reg1   = '0;
    w_reg2   = '0;
    w_alu_op = ALU_ADD;

    case (w_opcode)
      OPC_OP: begin
        w_reg1 = i_rs1_data;
        w_reg2 = i_rs2_data;
        case (w_funct7)
          F7_BASE: begin
            w_legal  = 1'b1;
            w_alu_op = base_op(w_funct3);
            if ((w_funct3 == F3_SLL) || (w_funct3 == F3_SRX)) begin
              w_reg2 = w_shamt_reg;
            end
          end
          F7_ALT: begin
            if (w_funct3 == 3'b000) begin
              w_legal  = 1'b1;
              w_alu_op = ALU_SUB;
            end else if (w_funct3 == F3_SRX) begin
              w_legal  = 1'b1;
              w_alu_op = ALU_SRA;
              w_reg2   = w_shamt_reg;
            end
          end
          F7_MULDIV: begin
            if (w_funct3 == 3'b000) begin
              w_legal  = 1'b1;
              w_alu_op = ALU_MUL;
            end
          end
          default: begin
            w_legal = 1'b0;
          end
        endcase
      end

      OPC_OP_IMM: begin
        w_reg1 = i_rs1_data;
        w_reg2 = w_imm_i;
        case (w_funct3)
          F3_SLL: begin
            w_legal  = (w_funct7 == F7_BASE);
            w_alu_op = ALU_SLL;
            w_reg2   = w_shamt_imm;
          end
          F3_SRX: begin
            w_reg2 = w_shamt_imm;
            if (w_funct7 == F7_BASE) begin
              w_legal  = 1'b1;
              w_alu_op = ALU_SRL;
            end else if (w_funct7 == F7_ALT) begin
              w_legal  = 1'b1;
              w_alu_op = ALU_SRA;
            end
          end
          default: begin
            w_legal  = 1'b1;
            w_alu_op = base_op(w_funct3);
          end
        endcase
      end

      OPC_LUI: begin
        w_legal = 1'b1;
        w_reg1  = '0;
        w_reg2  = w_imm_u;
      end

      OPC_AUIPC: begin
        w_legal = 1'b1;
        w_reg1  = i_pc;
        w_reg2  = w_imm_u;
      end

      default: begin
        w_legal = 1'b0;
      end
    endcase

    if (!w_legal) begin
      w_reg1   = '0;
      w_reg2   = '0;
      w_alu_op = ALU_ADD;
    end
  end

  assign o_reg1    = w_reg1;
  assign o_reg2    = w_reg2;
  assign o_alu_op  = w_alu_op;
  assign o_rd      = w_rd;
  assign o_we      = w_legal && (w_rd != 5'd0);
  assign o_illegal = !w_legal;

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Purpose:
//   Single-entry issue register between register-file read and the execute
//   stage. Decodes one instruction per valid/ready handshake (via
//   alu_op_decode) and holds Reg1/Reg2/AluOP/rd for the ALU, with stall,
//   flush and a count of ops handed downstream.
//
// Ports:
//   clk          in  1     rising-edge clock
//   rst          in  1     synchronous active-high reset
//   in_valid     in  1     upstream holds an instruction
//   in_ready     out 1     stage accepts this cycle
//   in_instr     in  32    raw instruction
//   in_pc        in  XLEN  pc of the instruction
//   in_rs1_data  in  XLEN  regfile rs1 data
//   in_rs2_data  in  XLEN  regfile rs2 data
//   flush        in  1     kill held entry, drop simultaneous input
//   out_valid    out 1     issue register holds an op
//   out_ready    in  1     execute stage consumes this cycle
//   Reg1         out XLEN  ALU operand A
//   Reg2         out XLEN  ALU operand B
//   AluOP        out OPW   ALU operation code
//   out_rd       out 5     destination register
//   out_we       out 1     write-back enable
//   out_illegal  out 1     undecodable instruction
//   issue_count  out 32    ops consumed downstream (wraps)
//   ex_fwd_valid in  1     (ALU_ISSUE_FWD_EN only) execute result valid
//   ex_fwd_rd    in  5     (ALU_ISSUE_FWD_EN only) execute result rd
//   ex_fwd_data  in  XLEN  (ALU_ISSUE_FWD_EN only) execute result value
//
// Configuration:
//   ALU_ISSUE_FWD_EN - when defined, rs1/rs2 may be taken from the execute
//   stage result instead of the register file.
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Reg1,
  output logic [XLEN-1:0] Reg2,
  output logic [OPW-1:0]  AluOP,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal,
  output logic [31:0]     issue_count
`ifdef ALU_ISSUE_FWD_EN
  ,
  input  logic            ex_fwd_valid,
  input  logic [4:0]      ex_fwd_rd,
  input  logic [XLEN-1:0] ex_fwd_data
`endif
);

  import alu_pkg::*;

  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic [XLEN-1:0] w_dec_reg1;
  logic [XLEN-1:0] w_dec_reg2;
  logic [4:0]      w_dec_op;
  logic [4:0]      w_dec_rd;
  logic            w_dec_we;
  logic            w_dec_illegal;
  logic            w_accept;
  logic            w_issue;

  logic            r_valid;
  logic [XLEN-1:0] r_reg1;
  logic [XLEN-1:0] r_reg2;
  logic [OPW-1:0]  r_alu_op;
  logic [4:0]      r_rd;
  logic            r_we;
  logic            r_illegal;
  logic [31:0]     r_issue_count;

`ifdef ALU_ISSUE_FWD_EN
  logic w_fwd_rs1;
  logic w_fwd_rs2;

  // Bypass from the execute stage. x0 is never forwarded since it reads as
  // zero. LUI/AUIPC never look at rs data, so muxing ahead of decode leaves
  // their operands untouched.
  assign w_fwd_rs1  = ex_fwd_valid && (ex_fwd_rd == in_instr[19:15]) &&
                      (in_instr[19:15] != 5'd0);
  assign w_fwd_rs2  = ex_fwd_valid && (ex_fwd_rd == in_instr[24:20]) &&
                      (in_instr[24:20] != 5'd0);
  assign w_rs1_data = w_fwd_rs1 ? ex_fwd_data : in_rs1_data;
  assign w_rs2_data = w_fwd_rs2 ? ex_fwd_data : in_rs2_data;
`else
  assign w_rs1_data = in_rs1_data;
  assign w_rs2_data = in_rs2_data;
`endif

  alu_op_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .i_instr    (in_instr),
    .i_pc       (in_pc),
    .i_rs1_data (w_rs1_data),
    .i_rs2_data (w_rs2_data),
    .o_reg1     (w_dec_reg1),
    .o_reg2     (w_dec_reg2),
    .o_alu_op   (w_dec_op),
    .o_rd       (w_dec_rd),
    .o_we       (w_dec_we),
    .o_illegal  (w_dec_illegal)
  );

  // Single-entry register: room exists when empty or draining this cycle.
  // During flush the held entry dies anyway, so ready is forced high to let
  // upstream drain; whatever it offers that cycle is dropped.
  assign in_ready = !r_valid || out_ready || flush;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_issue  = r_valid && out_ready && !flush;

  // Issue register, handshake and downstream op counter. Payload registers
  // load only on accept, so a stalled entry holds every output stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid       <= 1'b0;
      r_reg1        <= '0;
      r_reg2        <= '0;
      r_alu_op      <= OPW'(ALU_ADD);
      r_rd          <= 5'd0;
      r_we          <= 1'b0;
      r_illegal     <= 1'b0;
      r_issue_count <= 32'd0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid   <= 1'b1;
        r_reg1    <= w_dec_reg1;
        r_reg2    <= w_dec_reg2;
        r_alu_op  <= OPW'(w_dec_op);
        r_rd      <= w_dec_rd;
        r_we      <= w_dec_we;
        r_illegal <= w_dec_illegal;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end

      if (w_issue) begin
        r_issue_count <= r_issue_count + 32'd1;
      end
    end
  end

  assign out_valid   = r_valid;
  assign Reg1        = r_reg1;
  assign Reg2        = r_reg2;
  assign AluOP       = r_alu_op;
  assign out_rd      = r_rd;
  assign out_we      = r_we;
  assign out_illegal = r_illegal;
  assign issue_count = r_issue_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Purpose:
//   Self-checking bench for alu_issue_stage. The driver pushes the expected
//   issue-register contents into a queue at the moment an instruction is
//   accepted; an independent monitor compares the queue head against the
//   DUT whenever out_valid is high (every stalled cycle as well as the
//   consuming one). Directed cases cover reset, ADD, SRAI, LUI, backpressure,
//   flush, illegal and reset mid-stall; a randomized phase follows.
//
// Configuration:
//   ALU_ISSUE_FWD_EN - connects the forwarding inputs and runs a short
//   forwarding check.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  typedef struct {
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Reg1;
  logic [31:0] Reg2;
  logic [4:0]  AluOP;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;
  logic [31:0] issue_count;
`ifdef ALU_ISSUE_FWD_EN
  logic        ex_fwd_valid = 1'b0;
  logic [4:0]  ex_fwd_rd = '0;
  logic [31:0] ex_fwd_data = '0;
`endif

  exp_t        expQ[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] modelCount = 0;
  int          opTable[int];
  bit          lastReady;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .OPW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Reg1        (Reg1),
    .Reg2        (Reg2),
    .AluOP       (AluOP),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .out_illegal (out_illegal),
    .issue_count (issue_count)
`ifdef ALU_ISSUE_FWD_EN
    ,
    .ex_fwd_valid(ex_fwd_valid),
    .ex_fwd_rd   (ex_fwd_rd),
    .ex_fwd_data (ex_fwd_data)
`endif
  );

  // Operation table keyed by funct7*8 + funct3, built from the ISA tables.
  task automatic initTable();
    opTable[0*8 + 0]  = 2;   // add
    opTable[0*8 + 1]  = 4;   // sll
    opTable[0*8 + 2]  = 9;   // slt
    opTable[0*8 + 3]  = 10;  // sltu
    opTable[0*8 + 4]  = 7;   // xor
    opTable[0*8 + 5]  = 5;   // srl
    opTable[0*8 + 6]  = 1;   // or
    opTable[0*8 + 7]  = 0;   // and
    opTable[32*8 + 0] = 3;   // sub
    opTable[32*8 + 5] = 6;   // sra
    opTable[1*8 + 0]  = 8;   // mul
  endtask

  function automatic exp_t mk(logic [31:0] r1, logic [31:0] r2, int op,
                              int rd, bit we, bit ill);
    exp_t e;
    e.reg1 = r1;
    e.reg2 = r2;
    e.op   = 5'(op);
    e.rd   = 5'(rd);
    e.we   = we;
    e.ill  = ill;
    return e;
  endfunction

  // Reference decode written from the instruction-set rules.
  function automatic exp_t refModel(logic [31:0] instr, logic [31:0] pc,
                                    logic [31:0] rs1, logic [31:0] rs2);
    exp_t       e;
    logic [6:0] opc;
    int         f3;
    int         f7;
    int         key;
    bit         legal;
    opc   = instr[6:0];
    f3    = int'(instr[14:12]);
    f7    = int'(instr[31:25]);
    key   = f7 * 8 + f3;
    legal = 1'b0;
    e     = mk(0, 0, 2, int'(instr[11:7]), 1'b0, 1'b0);
    if (opc == 7'h33) begin
      if (opTable.exists(key)) begin
        legal  = 1'b1;
        e.op   = 5'(opTable[key]);
        e.reg1 = rs1;
        e.reg2 = (f3 == 1 || f3 == 5) ? (rs2 % 32) : rs2;
      end
    end else if (opc == 7'h13) begin
      e.reg1 = rs1;
      if (f3 == 1 || f3 == 5) begin
        legal  = (f7 == 0) || (f3 == 5 && f7 == 32);
        e.reg2 = 32'(instr[24:20]);
        if (legal) e.op = 5'(opTable[key]);
      end else begin
        legal  = 1'b1;
        e.op   = 5'(opTable[f3]);
        e.reg2 = 32'($signed(instr[31:20]));
      end
    end else if (opc == 7'h37 || opc == 7'h17) begin
      legal  = 1'b1;
      e.reg1 = (opc == 7'h17) ? pc : 32'd0;
      e.reg2 = instr & 32'hFFFF_F000;
    end
    if (!legal) begin
      e.reg1 = 0;
      e.reg2 = 0;
      e.op   = 2;
    end
    e.we  = legal && (e.rd != 0);
    e.ill = !legal;
    return e;
  endfunction

  function automatic logic [31:0] genInstr();
    logic [6:0] opc;
    logic [6:0] f7;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: opc = 7'h33;
      4, 5, 6:    opc = 7'h13;
      7:          opc = 7'h37;
      8:          opc = 7'h17;
      default:    opc = 7'($urandom);
    endcase
    case ($urandom_range(0, 4))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      3:       f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Compare the issue register against one expected entry; rd is only
  // meaningful for legal ops.
  task automatic checkOutput(exp_t e);
    bit bad;
    compared++;
    bad = (Reg1 !== e.reg1) || (Reg2 !== e.reg2) || (AluOP !== e.op) ||
          (out_we !== e.we) || (out_illegal !== e.ill) ||
          (!e.ill && (out_rd !== e.rd));
    if (bad) begin
      mismatched++;
      $display("[TB] FAIL issue_entry: got r1=%08h r2=%08h op=%0d rd=%0d we=%0b ill=%0b, expected r1=%08h r2=%08h op=%0d rd=%0d we=%0b ill=%0b",
               Reg1, Reg2, AluOP, out_rd, out_we, out_illegal,
               e.reg1, e.reg2, e.op, e.rd, e.we, e.ill);
    end
  endtask

  // One clock of stimulus: drive, bookkeep at the falling edge, step past
  // the next rising edge.
  task automatic applyStimulus(bit v, logic [31:0] instr, logic [31:0] pc,
                               logic [31:0] rs1, logic [31:0] rs2,
                               bit oready, bit fl, exp_t e, output bit acc);
    in_valid    = v;
    in_instr    = instr;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    out_ready   = oready;
    flush       = fl;
    @(negedge clk);
    lastReady = in_ready;
    acc = v && in_ready && !fl;
    if (fl && out_valid && expQ.size() > 0) void'(expQ.pop_front());
    if (acc) expQ.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(bit oready);
    bit acc;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, oready, 1'b0,
                  mk(0, 0, 2, 0, 0, 0), acc);
  endtask

  // Monitor: checks every cycle the DUT presents an op; consumes on ready.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && flush === 1'b0) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_out: out_valid=1, expected no pending op");
        end else begin
          checkOutput(expQ[0]);
          if (out_ready) begin
            checkVal("issue_count", issue_count, modelCount);
            modelCount = modelCount + 1;
            void'(expQ.pop_front());
          end
        end
      end
    end
  end

  initial begin
    bit          acc;
    logic [31:0] cntBefore;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    bit          v;
    bit          ordy;
    bit          fl;
    int          waitCycles;

    initTable();

    // Reset held for two edges, checked while still asserted.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rst_out_valid", 32'(out_valid), 0);
    checkVal("rst_reg1", Reg1, 0);
    checkVal("rst_reg2", Reg2, 0);
    checkVal("rst_aluop", 32'(AluOP), 2);
    checkVal("rst_rd", 32'(out_rd), 0);
    checkVal("rst_we", 32'(out_we), 0);
    checkVal("rst_illegal", 32'(out_illegal), 0);
    checkVal("rst_count", issue_count, 0);
    checkVal("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // add x1,x2,x3 ; srai x1,x3,3 ; lui x2,8
    applyStimulus(1, 32'h003100B3, 32'h100, 5, 7, 1, 0, mk(5, 7, 2, 1, 1, 0), acc);
    checkVal("add_accept", 32'(acc), 1);
    applyStimulus(1, 32'h4031D093, 32'h104, 32'h8000_0010, 0, 1, 0,
                  mk(32'h8000_0010, 3, 6, 1, 1, 0), acc);
    applyStimulus(1, 32'h00008137, 32'h108, 9, 9, 1, 0,
                  mk(0, 32'h0000_8000, 2, 2, 1, 0), acc);

    // Backpressure: lui is held while a sub x5,x6,x7 waits upstream.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h407302B3, 32'h10C, 20, 6, 0, 0, mk(14, 0, 3, 5, 1, 0), acc);
      checkVal("stall_in_ready", 32'(lastReady), 0);
    end
    cntBefore = modelCount;
    applyStimulus(1, 32'h407302B3, 32'h10C, 20, 6, 1, 0, mk(20, 6, 3, 5, 1, 0), acc);
    checkVal("release_accept", 32'(acc), 1);
    checkVal("release_count", issue_count, cntBefore + 1);

    // Flush while sub is held under stall, with an input offered.
    applyStimulus(1, 32'h003100B3, 32'h110, 1, 1, 0, 1, mk(1, 1, 2, 1, 1, 0), acc);
    checkVal("flush_in_ready", 32'(lastReady), 1);
    checkVal("flush_out_valid", 32'(out_valid), 0);
    checkVal("flush_count", issue_count, modelCount);

    // Illegal instruction still reaches the output.
    applyStimulus(1, 32'hFFFFFFFF, 32'h114, 3, 4, 1, 0, mk(0, 0, 2, 31, 0, 1), acc);
    idle(1);

    // Reset while an entry is stalled discards it.
    applyStimulus(1, 32'h00A00513, 32'h118, 0, 0, 1, 0, mk(0, 10, 2, 10, 1, 0), acc);
    idle(0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    expQ.delete();
    modelCount = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkVal("rst_stall_valid", 32'(out_valid), 0);
    checkVal("rst_stall_count", issue_count, 0);

`ifdef ALU_ISSUE_FWD_EN
    ex_fwd_valid = 1'b1;
    ex_fwd_rd    = 5'd2;
    ex_fwd_data  = 32'h0000_DEAD;
    applyStimulus(1, 32'h003100B3, 32'h120, 5, 7, 1, 0,
                  mk(32'h0000_DEAD, 7, 2, 1, 1, 0), acc);
    ex_fwd_rd = 5'd0;
    applyStimulus(1, 32'h003100B3, 32'h124, 5, 7, 1, 0, mk(5, 7, 2, 1, 1, 0), acc);
    ex_fwd_valid = 1'b0;
    idle(1);
`endif

    // Randomized traffic with random backpressure and occasional flush.
    for (int n = 0; n < 600; n++) begin
      v     = ($urandom_range(0, 3) != 0);
      ordy  = ($urandom_range(0, 3) != 0);
      fl    = ($urandom_range(0, 15) == 0);
      instr = genInstr();
      pc    = $urandom;
      rs1   = $urandom;
      rs2   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      applyStimulus(v, instr, pc, rs1, rs2, ordy, fl,
                    refModel(instr, pc, rs1, rs2), acc);
    end

    // Drain with a bounded wait.
    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      idle(1);
      waitCycles++;
    end
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain_timeout: %0d entries pending, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
